// File: rtl/riscv_dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding,
// wait-state counter width and the LSU operation encoding used to
// interpret the write-enable line.
package riscv_dmem_responder_pkg;

    // Responder FSM states: idle/accepting, counting wait states, presenting the response
    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_e;

    // Width of the wait-state counter (WAIT_CYCLES ranges 0..15)
    localparam int DMEM_WAIT_W = 4;

    // LSU operation as carried on the data_we_i line
    typedef enum logic {
        LSU_OP_LD = 1'b0,
        LSU_OP_WR = 1'b1
    } lsu_op_e;

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// LSU data bus between the core (master) and a memory responder (slave).
// The _i/_o suffixes are named from the responder's point of view.
interface riscv_dmem_responder_if;

    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_i,
        output data_we_i,
        output data_be_i,
        output data_addr_i,
        output data_wdata_i,
        input  data_gnt_o,
        input  data_rvalid_o,
        input  data_rdata_o,
        input  data_err_o
    );

    modport slave (
        input  data_req_i,
        input  data_we_i,
        input  data_be_i,
        input  data_addr_i,
        input  data_wdata_i,
        output data_gnt_o,
        output data_rvalid_o,
        output data_rdata_o,
        output data_err_o
    );

endinterface

// File: rtl/riscv_dmem_responder_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// A read only updates rdata when en is high and we is low, so the last
// read word stays on rdata until the next read.
module riscv_dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] r_mem [DEPTH];

    // Byte-lane write or full-word registered read of the addressed word
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int n = 0; n < 4; n++) begin
                    if (be[n]) begin
                        r_mem[idx][8*n +: 8] <= wdata[8*n +: 8];
                    end
                end
            end else begin
                rdata <= r_mem[idx];
            end
        end
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Memory-side responder for the LSU data interface. Accepts one request at
// a time, optionally waits WAIT_CYCLES, performs the RAM access and returns
// exactly one rvalid pulse per accepted request.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN -- when defined, word indices
// at or beyond DEPTH fault instead of aliasing modulo DEPTH.
module riscv_dmem_responder
    import riscv_dmem_responder_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    riscv_dmem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK = 1'b1;
`else
    localparam bit BOUNDS_CHECK = 1'b0;
`endif

    dmem_state_e            r_state;
    logic [DMEM_WAIT_W-1:0] r_cnt;
    logic                   r_we;
    logic [3:0]             r_be;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic                   r_rvalid;
    logic                   r_err;
    logic                   r_respLoad;
    logic [31:0]            r_rdataHold;

    logic                   w_gnt;
    logic                   w_access;
    logic                   w_accWe;
    logic [3:0]             w_accBe;
    logic [31:0]            w_accAddr;
    logic [31:0]            w_accWdata;
    logic [31:0]            w_offs;
    logic                   w_misaligned;
    logic                   w_outOfRange;
    logic                   w_fault;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_ramEn;
    logic [31:0]            w_ramRdata;
    logic [31:0]            w_rdataOut;

    assign w_gnt = bus.data_req_i && (r_state == DMEM_IDLE);

    // Pick the access source: with no wait states the access happens on the
    // grant edge straight from the bus, otherwise from the captured request
    always_comb begin
        w_accWe    = r_we;
        w_accBe    = r_be;
        w_accAddr  = r_addr;
        w_accWdata = r_wdata;
        w_access   = (r_state == DMEM_WAIT) && (r_cnt == DMEM_WAIT_W'(1));
        if (WAIT_CYCLES == 0) begin
            w_accWe    = bus.data_we_i;
            w_accBe    = bus.data_be_i;
            w_accAddr  = bus.data_addr_i;
            w_accWdata = bus.data_wdata_i;
            w_access   = w_gnt;
        end
    end

    // Address decode and fault detection relative to the RAM window
    always_comb begin
        w_offs       = w_accAddr - BASE_ADDR;
        w_misaligned = |w_offs[1:0];
        w_outOfRange = ({2'b00, w_offs[31:2]} >= 32'(DEPTH));
        w_fault      = w_misaligned || (BOUNDS_CHECK && w_outOfRange);
        w_idx        = w_offs[IDX_W+1:2];
        w_ramEn      = w_access && !w_fault && (!w_accWe || (|w_accBe));
    end

    riscv_dmem_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .en    (w_ramEn),
        .we    (w_accWe),
        .be    (w_accBe),
        .idx   (w_idx),
        .wdata (w_accWdata),
        .rdata (w_ramRdata)
    );

    // Response data: RAM word for a good load, zero for stores and faults,
    // then the last response value is held until the next one
    always_comb begin
        w_rdataOut = r_rdataHold;
        if (r_state == DMEM_RESP) begin
            w_rdataOut = r_respLoad ? w_ramRdata : 32'h0;
        end
    end

    // Request FSM: grant in IDLE, count wait states, pulse rvalid in RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= DMEM_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_be        <= 4'h0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
            r_respLoad  <= 1'b0;
            r_rdataHold <= 32'h0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                DMEM_IDLE: begin
                    if (w_gnt) begin
                        r_we    <= bus.data_we_i;
                        r_be    <= bus.data_be_i;
                        r_addr  <= bus.data_addr_i;
                        r_wdata <= bus.data_wdata_i;
                        if (WAIT_CYCLES == 0) begin
                            r_state    <= DMEM_RESP;
                            r_rvalid   <= 1'b1;
                            r_err      <= w_fault;
                            r_respLoad <= !w_accWe && !w_fault;
                        end else begin
                            r_cnt   <= DMEM_WAIT_W'(WAIT_CYCLES);
                            r_state <= DMEM_WAIT;
                        end
                    end
                end
                DMEM_WAIT: begin
                    if (w_access) begin
                        r_state    <= DMEM_RESP;
                        r_rvalid   <= 1'b1;
                        r_err      <= w_fault;
                        r_respLoad <= !w_accWe && !w_fault;
                    end else begin
                        r_cnt <= r_cnt - DMEM_WAIT_W'(1);
                    end
                end
                DMEM_RESP: begin
                    r_rdataHold <= w_rdataOut;
                    r_state     <= DMEM_IDLE;
                end
                default: begin
                    r_state <= DMEM_IDLE;
                end
            endcase
        end
    end

    assign bus.data_gnt_o    = w_gnt;
    assign bus.data_rvalid_o = r_rvalid;
    assign bus.data_rdata_o  = w_rdataOut;
    assign bus.data_err_o    = r_err;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: one instance with no wait states and one
// with three, driven through the LSU interface and compared against a
// word-array memory model. Honours DMEM_BOUNDS_CHECK_EN when defined.
module tb_riscv_dmem_responder;
    import riscv_dmem_responder_pkg::*;

    localparam int DEPTH = 1024;
    localparam int W0    = 0;
    localparam int W1    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    riscv_dmem_responder_if bus0 ();
    riscv_dmem_responder_if bus1 ();

    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic        tbWe = 1'b0;
    logic [3:0]  tbBe = 4'h0;
    logic [31:0] tbAddr = 32'h0;
    logic [31:0] tbWdata = 32'h0;

    assign bus0.data_req_i   = req0;
    assign bus0.data_we_i    = tbWe;
    assign bus0.data_be_i    = tbBe;
    assign bus0.data_addr_i  = tbAddr;
    assign bus0.data_wdata_i = tbWdata;
    assign bus1.data_req_i   = req1;
    assign bus1.data_we_i    = tbWe;
    assign bus1.data_be_i    = tbBe;
    assign bus1.data_addr_i  = tbAddr;
    assign bus1.data_wdata_i = tbWdata;

    riscv_dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(W0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    riscv_dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(W1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int          sel = 0;
    logic        obsGnt;
    logic        obsRvalid;
    logic        obsErr;
    logic [31:0] obsRdata;

    // Observe whichever instance the current test is talking to
    always_comb begin
        obsGnt    = (sel == 0) ? bus0.data_gnt_o    : bus1.data_gnt_o;
        obsRvalid = (sel == 0) ? bus0.data_rvalid_o : bus1.data_rvalid_o;
        obsErr    = (sel == 0) ? bus0.data_err_o    : bus1.data_err_o;
        obsRdata  = (sel == 0) ? bus0.data_rdata_o  : bus1.data_rdata_o;
    end

    int errors = 0;
    int checks = 0;

    logic [31:0] modelMem   [2][DEPTH];
    bit          modelKnown [2][DEPTH];

    // Reference memory: byte offset from base, word number, fault rules
    task automatic modelAccess(input int s, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic expErr, output logic [31:0] expData,
                               output bit expKnown);
        logic [31:0] offs;
        logic [31:0] wordNum;
        int          idx;
        offs     = addr - 32'h0;
        wordNum  = offs / 4;
        expErr   = 1'b0;
        expData  = 32'h0;
        expKnown = 1'b1;
        if ((offs % 4) != 0) expErr = 1'b1;
`ifdef DMEM_BOUNDS_CHECK_EN
        if (wordNum >= 32'(DEPTH)) expErr = 1'b1;
`endif
        if (!expErr) begin
            idx = int'(wordNum % 32'(DEPTH));
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) modelMem[s][idx][8*b +: 8] = wdata[8*b +: 8];
                end
                if (be == 4'hF) modelKnown[s][idx] = 1'b1;
            end else begin
                expData  = modelMem[s][idx];
                expKnown = modelKnown[s][idx];
            end
        end
    endtask

    // One complete request/response on instance s, checked against the model
    task automatic doTxn(input int s, input lsu_op_e op, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input string name);
        int          waitCnt;
        int          lat;
        int          expLat;
        logic        expErr;
        logic [31:0] expData;
        bit          expKnown;
        sel     = s;
        tbWe    = (op == LSU_OP_WR);
        tbBe    = be;
        tbAddr  = addr;
        tbWdata = wdata;
        if (s == 0) req0 = 1'b1; else req1 = 1'b1;
        waitCnt = 0;
        @(negedge clk);
        while (!obsGnt && waitCnt < 20) begin
            waitCnt++;
            @(negedge clk);
        end
        checks++;
        if (obsGnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s gnt: got %b after %0d cycles, want 1", name, obsGnt, waitCnt);
            req0 = 1'b0;
            req1 = 1'b0;
            @(posedge clk); #1;
            return;
        end
        modelAccess(s, tbWe, be, addr, wdata, expErr, expData, expKnown);
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        expLat = ((s == 0) ? W0 : W1) + 1;
        lat = 1;
        @(negedge clk);
        while (!obsRvalid && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        checks++;
        if (obsRvalid !== 1'b1 || lat != expLat) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d (rvalid=%b), want %0d", name, lat, obsRvalid, expLat);
        end
        checks++;
        if (obsErr !== expErr) begin
            errors++;
            $display("[TB] FAIL %s err: got %b, want %b", name, obsErr, expErr);
        end
        if (expKnown) begin
            checks++;
            if (obsRdata !== expData) begin
                errors++;
                $display("[TB] FAIL %s rdata: got %h, want %h", name, obsRdata, expData);
            end
        end
        @(negedge clk);
        checks++;
        if (obsRvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s single rvalid: got %b, want 0", name, obsRvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            checks++;
            if (obsRvalid !== 1'b0 || obsErr !== 1'b0 || obsRdata !== 32'h0 || obsGnt !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset inst%0d: rvalid=%b err=%b rdata=%h gnt=%b, want all 0",
                         s, obsRvalid, obsErr, obsRdata, obsGnt);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_store();
        doTxn(0, LSU_OP_WR, 4'hF, 32'h10, 32'hDEADBEEF, "store_full");
        doTxn(0, LSU_OP_LD, 4'hF, 32'h10, 32'h0, "load_full");
        doTxn(0, LSU_OP_WR, 4'b0100, 32'h10, 32'h00AA0000, "store_byte");
        doTxn(0, LSU_OP_LD, 4'h0, 32'h10, 32'h0, "load_after_byte");
        repeat (2) @(negedge clk);
        checks++;
        if (obsRdata !== 32'hDEAABEEF) begin
            errors++;
            $display("[TB] FAIL rdata_hold: got %h, want deaabeef", obsRdata);
        end
        @(posedge clk); #1;
        doTxn(0, LSU_OP_WR, 4'h0, 32'h10, 32'h55555555, "store_be0");
        doTxn(0, LSU_OP_LD, 4'hF, 32'h12, 32'h0, "load_misaligned");
        doTxn(0, LSU_OP_WR, 4'hF, 32'h11, 32'h77777777, "store_misaligned");
        doTxn(0, LSU_OP_LD, 4'hF, 32'h10, 32'h0, "load_after_fault");
    endtask

    task automatic test_out_of_range();
        doTxn(0, LSU_OP_WR, 4'hF, 32'h0, 32'h12345678, "store_word0");
        doTxn(0, LSU_OP_WR, 4'hF, 32'h4, 32'h0BADC0DE, "store_word1");
        doTxn(0, LSU_OP_LD, 4'hF, 32'h1000, 32'h0, "load_oor");
        doTxn(0, LSU_OP_WR, 4'hF, 32'h1004, 32'hCAFEF00D, "store_oor");
        doTxn(0, LSU_OP_LD, 4'hF, 32'h4, 32'h0, "load_word1_after_oor");
    endtask

    task automatic test_back_to_back();
        logic        gntSeen [10];
        logic        rvSeen  [10];
        logic        expErr;
        logic [31:0] expData;
        bit          expKnown;
        doTxn(1, LSU_OP_WR, 4'hF, 32'h10, 32'hDEADBEEF, "w3_store_full");
        doTxn(1, LSU_OP_WR, 4'b0100, 32'h10, 32'h00AA0000, "w3_store_byte");
        modelAccess(1, 1'b0, 4'hF, 32'h10, 32'h0, expErr, expData, expKnown);
        sel    = 1;
        tbWe   = 1'b0;
        tbBe   = 4'hF;
        tbAddr = 32'h10;
        req1   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            gntSeen[c] = obsGnt;
            rvSeen[c]  = obsRvalid;
            if (obsRvalid === 1'b1) begin
                checks++;
                if (obsRdata !== expData || obsErr !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b rdata c%0d: got %h err=%b, want %h err=0", c, obsRdata, obsErr, expData);
                end
            end
        end
        req1 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (gntSeen[c] !== ((c == 0) || (c == 5)) || rvSeen[c] !== ((c == 4) || (c == 9))) begin
                errors++;
                $display("[TB] FAIL b2b cycle %0d: gnt=%b rvalid=%b, want gnt=%b rvalid=%b",
                         c, gntSeen[c], rvSeen[c], (c == 0) || (c == 5), (c == 4) || (c == 9));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wait();
        int waitCnt;
        int rvCount;
        doTxn(1, LSU_OP_LD, 4'hF, 32'h10, 32'h0, "w3_load_before_rst");
        sel     = 1;
        tbWe    = 1'b1;
        tbBe    = 4'hF;
        tbAddr  = 32'h10;
        tbWdata = 32'h11111111;
        req1    = 1'b1;
        waitCnt = 0;
        @(negedge clk);
        while (!obsGnt && waitCnt < 20) begin
            waitCnt++;
            @(negedge clk);
        end
        checks++;
        if (obsGnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_wait gnt: got %b, want 1", obsGnt);
        end
        @(posedge clk); #1;
        req1 = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obsRvalid !== 1'b0 || obsRdata !== 32'h0 || obsErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_wait outputs: rvalid=%b rdata=%h err=%b, want 0/0/0", obsRvalid, obsRdata, obsErr);
        end
        @(negedge clk);
        rst = 1'b0;
        rvCount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (obsRvalid === 1'b1) rvCount++;
        end
        checks++;
        if (rvCount != 0) begin
            errors++;
            $display("[TB] FAIL rst_wait stray rvalid: got %0d pulses, want 0", rvCount);
        end
        @(posedge clk); #1;
        doTxn(1, LSU_OP_LD, 4'hF, 32'h10, 32'h0, "w3_load_after_rst");
        checks++;
        if (obsRdata !== 32'hDEAABEEF) begin
            errors++;
            $display("[TB] FAIL rst_wait ram kept: got %h, want deaabeef", obsRdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          word;
        int          kind;
        lsu_op_e     op;
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) begin
                doTxn(s, LSU_OP_WR, 4'hF, 32'(w * 4), $urandom, "rnd_init");
            end
            for (int n = 0; n < 40; n++) begin
                word = $urandom_range(0, 15);
                kind = $urandom_range(0, 9);
                addr = 32'(word * 4);
                if (kind == 7) addr = addr + 32'($urandom_range(1, 3));
                else if (kind >= 8) addr = addr + 32'(32'h1000 * $urandom_range(1, 3));
                op = ($urandom_range(0, 1) == 1) ? LSU_OP_WR : LSU_OP_LD;
                doTxn(s, op, 4'($urandom), addr, $urandom, "rnd");
            end
        end
    endtask

    // Test sequence and summary
    initial begin
        test_reset();
        test_load_store();
        test_out_of_range();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
